// File: rtl/axi_master_read_engine.sv
// AXI4 read master: splits one DMA read command into INCR bursts capped
// at MAX_BURST beats and 4 KB pages, streaming data into the DMA FIFO.
module axi_master_read_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_beats,
  output logic                  busy,
  output logic                  done,
  input  logic                  done_ack,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  input  logic                  RVALID,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RLAST,
  input  logic [1:0]            RRESP,
  output logic                  RREADY,
  output logic                  master2dma_afifo_wpush,
  output logic [DATA_WIDTH-1:0] master2dma_afifo_wdata,
  input  logic                  master2dma_afifo_wfull
);

  localparam int SZ = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = {ADDR_WIDTH{1'b1}} << SZ;
  localparam logic [12:0] MAXB = 13'(MAX_BURST);

  typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, DONE} state_t;
  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [8:0]            blen;
  logic [8:0]            beat_cnt;
  logic [1:0]            ecode;
  logic [12:0]           to_4k;
  logic [12:0]           cap;
  logic [8:0]            blen_n;
  logic                  beat;
  logic                  last_idx;
  logic                  burst_end;
  logic                  more;
  logic                  unused_rresp;

  assign unused_rresp = RRESP[0];

  // Beats left before the next 4 KB page starts.
  assign to_4k = (13'd4096 - {1'b0, addr[11:0]}) >> SZ;
  assign cap = (to_4k < MAXB) ? to_4k : MAXB;
  assign blen_n = (32'(remaining) < 32'(cap)) ?
                  9'(remaining) : 9'(cap);

  assign beat = (state == DATA) && RVALID && RREADY;
  assign last_idx = (beat_cnt == blen - 9'd1);
  // A missing RLAST still closes the burst after blen beats.
  assign burst_end = beat && (RLAST || last_idx);
  assign more = (remaining != CNT_WIDTH'(blen));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = (cmd_beats != '0) ? CALC : DONE;
      CALC: state_n = ADDR;
      ADDR: if (ARREADY) state_n = DATA;
      DATA: if (burst_end) state_n = more ? CALC : DONE;
      DONE: if (done_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err = done && (|ecode);
  assign err_code = done ? ecode : 2'b00;
  assign ARVALID = (state == ADDR);
  assign ARADDR = ARVALID ? addr : '0;
  assign ARLEN = ARVALID ? 8'(blen - 9'd1) : 8'd0;
  assign ARSIZE = 3'(SZ);
  assign ARBURST = 2'b01;
  assign RREADY = (state == DATA) && !master2dma_afifo_wfull;
  assign master2dma_afifo_wpush = beat;
  assign master2dma_afifo_wdata = beat ? RDATA : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      blen      <= '0;
      beat_cnt  <= '0;
      ecode     <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          addr      <= cmd_addr & ALIGN;
          remaining <= cmd_beats;
          ecode     <= '0;
        end
        CALC: blen <= blen_n;
        ADDR: beat_cnt <= '0;
        DATA: if (beat) begin
          beat_cnt <= beat_cnt + 9'd1;
          if (RRESP[1]) ecode[0] <= 1'b1;
          if (RLAST != last_idx) ecode[1] <= 1'b1;
          if (burst_end) begin
            addr      <= addr + (ADDR_WIDTH'(blen) << SZ);
            remaining <= remaining - CNT_WIDTH'(blen);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_read_engine.sv
// Directed bench for axi_master_read_engine: a reactive AXI slave plus a
// burst-splitting reference model checked every cycle against the DUT.
module tb_axi_master_read_engine;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] cmd_addr;
  logic [CW-1:0] cmd_beats;
  logic          busy;
  logic          done;
  logic          done_ack;
  logic          err;
  logic [1:0]    err_code;
  logic [AW-1:0] ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          RVALID;
  logic [DW-1:0] RDATA;
  logic          RLAST;
  logic [1:0]    RRESP;
  logic          RREADY;
  logic          wpush;
  logic [DW-1:0] wdata;
  logic          wfull;

  axi_master_read_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_BURST(MB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .busy(busy), .done(done), .done_ack(done_ack),
    .err(err), .err_code(err_code),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RDATA(RDATA), .RLAST(RLAST),
    .RRESP(RRESP), .RREADY(RREADY),
    .master2dma_afifo_wpush(wpush),
    .master2dma_afifo_wdata(wdata),
    .master2dma_afifo_wfull(wfull)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  len;
  } ar_t;

  int checks = 0;
  int failures = 0;

  ar_t         exp_ar[$];
  logic [31:0] exp_d[$];
  ar_t         ar_log[$];
  int          npush;
  logic [1:0]  last_ec;
  logic        last_err;
  bit          mon_on = 1'b0;

  // slave knobs
  int ar_wait = 0;
  bit wf_toggle = 1'b0;
  int err_beat = -1;
  int cut_b = -1;
  int cut_n = 0;
  int s_burst = 0;
  int g_idx = 0;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: split into bursts by beats left, MB and the 4 KB page.
  task automatic build(input logic [31:0] a0, input int n,
                       output logic [1:0] ec);
    int rem;
    int bi;
    int total;
    int to4k;
    int b;
    int k;
    logic [31:0] a;
    rem = n;
    bi = 0;
    total = 0;
    a = a0 & ~32'h3;
    ec = 2'b00;
    exp_ar.delete();
    exp_d.delete();
    while (rem > 0) begin
      to4k = (4096 - int'(a[11:0])) / 4;
      b = rem;
      if (b > MB) b = MB;
      if (b > to4k) b = to4k;
      exp_ar.push_back('{a, 8'(b - 1)});
      k = b;
      if (bi == cut_b) begin
        k = cut_n;
        ec[1] = 1'b1;
      end
      for (int i = 0; i < k; i++) begin
        exp_d.push_back(fdata(a + 32'(4 * i)));
        total++;
      end
      a = a + 32'(4 * b);
      rem = rem - b;
      bi++;
    end
    if (err_beat >= 0 && err_beat < total) ec[0] = 1'b1;
  endtask

  // Reactive slave and FIFO-full driver.
  initial begin
    logic ar_hs, r_hs, arv;
    logic [31:0] s_a;
    logic [7:0] s_l;
    logic [31:0] r_a;
    int r_idx, r_cut, ar_cnt;
    bit r_act;
    r_act = 1'b0;
    r_idx = 0;
    r_cut = 0;
    ar_cnt = 0;
    r_a = '0;
    ARREADY = 1'b0;
    RVALID = 1'b0;
    RDATA = '0;
    RLAST = 1'b0;
    RRESP = 2'b00;
    wfull = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = ARVALID && ARREADY;
      r_hs = RVALID && RREADY;
      arv = ARVALID;
      s_a = ARADDR;
      s_l = ARLEN;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        r_act = 1'b0;
        ar_cnt = 0;
      end else begin
        if (r_hs) begin
          g_idx++;
          if (r_idx == r_cut - 1) r_act = 1'b0;
          else r_idx++;
        end
        if (ar_hs) begin
          r_act = 1'b1;
          r_a = s_a;
          r_idx = 0;
          r_cut = (s_burst == cut_b) ? cut_n : int'(s_l) + 1;
          s_burst++;
          ar_cnt = 0;
        end else if (arv) begin
          ar_cnt++;
        end
      end
      RVALID = r_act;
      RDATA = r_act ? fdata(r_a + 32'(4 * r_idx)) : '0;
      RLAST = r_act && (r_idx == r_cut - 1);
      RRESP = (r_act && g_idx == err_beat) ? 2'b10 : 2'b00;
      ARREADY = (ar_wait == 0) || (ar_cnt >= ar_wait);
      wfull = wf_toggle ? !wfull : 1'b0;
    end
  end

  // Per-cycle compare against the reference queues.
  logic        p_arv = 1'b0;
  logic        p_arr = 1'b0;
  logic [31:0] p_a;
  logic [7:0]  p_l;
  ar_t         mon_e;

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (ARVALID && ARREADY) begin
        ar_log.push_back('{ARADDR, ARLEN});
        if (exp_ar.size() == 0) begin
          chk("ar_extra", 64'(ARADDR), 64'hFFFF_FFFF);
        end else begin
          mon_e = exp_ar.pop_front();
          chk("ar_addr", 64'(ARADDR), 64'(mon_e.a));
          chk("ar_len", 64'(ARLEN), 64'(mon_e.len));
        end
      end
      if (p_arv && !p_arr) begin
        chk("ar_hold_valid", 64'(ARVALID), 64'd1);
        chk("ar_hold_addr", 64'(ARADDR), 64'(p_a));
        chk("ar_hold_len", 64'(ARLEN), 64'(p_l));
      end
      chk("rready_while_full", 64'(RREADY && wfull), 64'd0);
      if (RVALID && !wfull) chk("rready_on", 64'(RREADY), 64'd1);
      chk("wpush_eq_hs", 64'(wpush), 64'(RVALID && RREADY));
      if (wpush) begin
        npush++;
        chk("push_while_full", 64'(wfull), 64'd0);
        if (exp_d.size() == 0) begin
          chk("push_extra", 64'(wdata), 64'hFFFF_FFFF_FFFF);
        end else begin
          chk("push_data", 64'(wdata), 64'(exp_d.pop_front()));
        end
      end
      chk("arsize", 64'(ARSIZE), 64'd2);
      chk("arburst", 64'(ARBURST), 64'd1);
      p_arv = ARVALID;
      p_arr = ARREADY;
      p_a = ARADDR;
      p_l = ARLEN;
    end
  end

  task automatic check_idle_outs(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_err"}, 64'(err), 64'd0);
    chk({nm, "_err_code"}, 64'(err_code), 64'd0);
    chk({nm, "_arvalid"}, 64'(ARVALID), 64'd0);
    chk({nm, "_araddr"}, 64'(ARADDR), 64'd0);
    chk({nm, "_arlen"}, 64'(ARLEN), 64'd0);
    chk({nm, "_rready"}, 64'(RREADY), 64'd0);
    chk({nm, "_wpush"}, 64'(wpush), 64'd0);
    chk({nm, "_wdata"}, 64'(wdata), 64'd0);
    chk({nm, "_arsize"}, 64'(ARSIZE), 64'd2);
    chk({nm, "_arburst"}, 64'(ARBURST), 64'd1);
  endtask

  task automatic run_cmd(input logic [31:0] a, input int n,
                         input bit both_ack);
    logic [1:0] ec;
    int k;
    int exp_n;
    build(a, n, ec);
    exp_n = exp_d.size();
    ar_log.delete();
    npush = 0;
    s_burst = 0;
    g_idx = 0;
    @(posedge clk);
    #1;
    cmd_addr = a;
    cmd_beats = CW'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    if (n == 0) begin
      chk("zl_done_cyc1", 64'(done), 64'd1);
      chk("zl_no_arvalid", 64'(ARVALID), 64'd0);
    end else begin
      chk("cyc1_busy", 64'(busy), 64'd1);
      chk("cyc1_arvalid", 64'(ARVALID), 64'd0);
      @(negedge clk);
      chk("cyc2_arvalid", 64'(ARVALID), 64'd1);
    end
    k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("ar_all_issued", 64'(exp_ar.size()), 64'd0);
    chk("push_all", 64'(exp_d.size()), 64'd0);
    chk("push_count", 64'(npush), 64'(exp_n));
    chk("err", 64'(err), 64'(|ec));
    chk("err_code", 64'(err_code), 64'(ec));
    last_ec = err_code;
    last_err = err;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_held", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    done_ack = 1'b1;
    start = both_ack;
    @(posedge clk);
    #1;
    done_ack = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_ack", 64'(busy), 64'd0);
    @(negedge clk);
    chk("start_not_latched", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [1:0] ec_tmp;
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    done_ack = 1'b0;
    cmd_addr = '0;
    cmd_beats = '0;
    #12;
    check_idle_outs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_on = 1'b1;

    // three bursts, 8+8+4
    run_cmd(32'h1000, 20, 1'b0);
    chk("t1_nar", 64'(ar_log.size()), 64'd3);
    chk("t1_ar0", {24'd0, ar_log[0]}, {24'd0, 32'h1000, 8'd7});
    chk("t1_ar1", {24'd0, ar_log[1]}, {24'd0, 32'h1020, 8'd7});
    chk("t1_ar2", {24'd0, ar_log[2]}, {24'd0, 32'h1040, 8'd3});
    chk("t1_npush", 64'(npush), 64'd20);

    // 4 KB split with a slow ARREADY
    ar_wait = 2;
    run_cmd(32'h1FF0, 8, 1'b1);
    ar_wait = 0;
    chk("t2_nar", 64'(ar_log.size()), 64'd2);
    chk("t2_ar0", {24'd0, ar_log[0]}, {24'd0, 32'h1FF0, 8'd3});
    chk("t2_ar1", {24'd0, ar_log[1]}, {24'd0, 32'h2000, 8'd3});

    // unaligned start just below a page boundary
    run_cmd(32'h0FFE, 3, 1'b0);
    chk("t3_ar0", {24'd0, ar_log[0]}, {24'd0, 32'h0FFC, 8'd0});
    chk("t3_ar1", {24'd0, ar_log[1]}, {24'd0, 32'h1000, 8'd1});

    // FIFO backpressure
    wf_toggle = 1'b1;
    run_cmd(32'h6000, 16, 1'b0);
    wf_toggle = 1'b0;
    chk("t4_npush", 64'(npush), 64'd16);

    // slave error on beat 3
    err_beat = 3;
    run_cmd(32'h5000, 8, 1'b0);
    err_beat = -1;
    chk("t5_err_code", 64'(last_ec), 64'd1);
    chk("t5_npush", 64'(npush), 64'd8);

    // early RLAST after 5 of 8 beats
    cut_b = 0;
    cut_n = 5;
    run_cmd(32'h4000, 16, 1'b0);
    cut_b = -1;
    chk("t6_ar1", {24'd0, ar_log[1]}, {24'd0, 32'h4020, 8'd7});
    chk("t6_err_code", 64'(last_ec), 64'd2);
    chk("t6_npush", 64'(npush), 64'd13);

    // zero-length command
    run_cmd(32'h8000, 0, 1'b0);
    chk("t7_nar", 64'(ar_log.size()), 64'd0);
    chk("t7_err", 64'(last_err), 64'd0);

    // reset in the middle of a burst
    build(32'h7000, 16, ec_tmp);
    ar_log.delete();
    npush = 0;
    s_burst = 0;
    g_idx = 0;
    @(posedge clk);
    #1;
    cmd_addr = 32'h7000;
    cmd_beats = 16'd16;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (npush < 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t8_reached_data", 64'(npush >= 5), 64'd1);
    @(posedge clk);
    #3;
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outs("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ar.delete();
    exp_d.delete();
    p_arv = 1'b0;
    p_arr = 1'b0;
    mon_on = 1'b1;
    run_cmd(32'h3000, 4, 1'b0);
    chk("t8_ar0", {24'd0, ar_log[0]}, {24'd0, 32'h3000, 8'd3});
    chk("t8_npush", 64'(npush), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
